// File: rtl/alu_share_arbiter_pkg.sv
// Shared datapath widths and ALU opcode encodings for the ALU-sharing arbiter.
package alu_share_arbiter_pkg;

  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned CORE_ALU_OP_WIDTH = 4;
  localparam int unsigned SHAMT_WIDTH       = 5;

  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_ADD  = 4'd0;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_SUB  = 4'd1;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_SLL  = 4'd2;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_SLT  = 4'd3;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_SLTU = 4'd4;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_XOR  = 4'd5;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_SRL  = 4'd6;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_SRA  = 4'd7;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_OR   = 4'd8;
  localparam logic [CORE_ALU_OP_WIDTH-1:0] CORE_ALU_AND  = 4'd9;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Purely combinational integer ALU; unknown opcodes produce zero.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [CORE_ALU_OP_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]        op0,
  input  logic [DATA_WIDTH-1:0]        op1,
  output logic [DATA_WIDTH-1:0]        result_c
);

  logic [SHAMT_WIDTH-1:0] shamt;

  assign shamt = op1[SHAMT_WIDTH-1:0];

  always_comb begin
    result_c = '0;
    case (opcode)
      CORE_ALU_ADD:  result_c = op0 + op1;
      CORE_ALU_SUB:  result_c = op0 - op1;
      CORE_ALU_SLL:  result_c = op0 << shamt;
      CORE_ALU_SLT:  result_c = DATA_WIDTH'($signed(op0) < $signed(op1));
      CORE_ALU_SLTU: result_c = DATA_WIDTH'(op0 < op1);
      CORE_ALU_XOR:  result_c = op0 ^ op1;
      CORE_ALU_SRL:  result_c = op0 >> shamt;
      CORE_ALU_SRA:  result_c = DATA_WIDTH'($signed(op0) >>> shamt);
      CORE_ALU_OR:   result_c = op0 | op1;
      CORE_ALU_AND:  result_c = op0 & op1;
      default:       result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters, each owning a one-entry
// registered result slot; round-robin or fixed-priority (port 0) grant.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [DATA_WIDTH-1:0]        req0_op0,
  input  logic [DATA_WIDTH-1:0]        req0_op1,
  input  logic [CORE_ALU_OP_WIDTH-1:0] req0_opcode,

  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [DATA_WIDTH-1:0]        req1_op0,
  input  logic [DATA_WIDTH-1:0]        req1_op1,
  input  logic [CORE_ALU_OP_WIDTH-1:0] req1_opcode,

  output logic                         rsp0_valid,
  output logic [DATA_WIDTH-1:0]        rsp0_data,
  input  logic                         rsp0_ready,

  output logic                         rsp1_valid,
  output logic [DATA_WIDTH-1:0]        rsp1_data,
  input  logic                         rsp1_ready
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P0   = 2'd1,
    GNT_P1   = 2'd2
  } gnt_e;

  gnt_e                         gnt_c;
  logic                         elig0_c;
  logic                         elig1_c;
  logic [DATA_WIDTH-1:0]        alu_op0_c;
  logic [DATA_WIDTH-1:0]        alu_op1_c;
  logic [CORE_ALU_OP_WIDTH-1:0] alu_opcode_c;
  logic [DATA_WIDTH-1:0]        alu_result_c;

  logic                         last_grant_q, last_grant_d;
  logic                         rsp0_valid_q, rsp0_valid_d;
  logic                         rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0]        rsp0_data_q,  rsp0_data_d;
  logic [DATA_WIDTH-1:0]        rsp1_data_q,  rsp1_data_d;

  // A slot draining this cycle can be refilled in the same cycle.
  always_comb begin
    elig0_c = !rst && req0_valid && (!rsp0_valid_q || rsp0_ready);
    elig1_c = !rst && req1_valid && (!rsp1_valid_q || rsp1_ready);
  end

  // On a tie, fixed mode always picks port 0; round-robin picks the port
  // that did not win last time.
  always_comb begin
    gnt_c = GNT_NONE;
    if (elig0_c && elig1_c) begin
      gnt_c = ((PRIORITY_MODE != 32'd0) || last_grant_q) ? GNT_P0 : GNT_P1;
    end else if (elig0_c) begin
      gnt_c = GNT_P0;
    end else if (elig1_c) begin
      gnt_c = GNT_P1;
    end
  end

  assign req0_ready = (gnt_c == GNT_P0);
  assign req1_ready = (gnt_c == GNT_P1);

  // Idle cycles leave port 0 on the ALU; that result is simply not captured.
  always_comb begin
    alu_op0_c    = req0_op0;
    alu_op1_c    = req0_op1;
    alu_opcode_c = req0_opcode;
    if (gnt_c == GNT_P1) begin
      alu_op0_c    = req1_op0;
      alu_op1_c    = req1_op1;
      alu_opcode_c = req1_opcode;
    end
  end

  alu_share_arbiter_alu u_alu (
    .opcode   (alu_opcode_c),
    .op0      (alu_op0_c),
    .op1      (alu_op1_c),
    .result_c (alu_result_c)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;

    if (gnt_c == GNT_P0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = alu_result_c;
    end else if (rsp0_valid_q && rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    if (gnt_c == GNT_P1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = alu_result_c;
    end else if (rsp1_valid_q && rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end

    if (gnt_c != GNT_NONE) begin
      last_grant_d = (gnt_c == GNT_P1);
    end
  end

  // last_grant resets to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same stimulus and
// compares both against a cycle-level behavioural model.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] op0 [2];
  logic [31:0] op1 [2];
  logic [3:0]  opc [2];

  logic [1:0]  rdy_w [2];
  logic [1:0]  vld_w [2];
  logic [31:0] dat_w [2][2];

  always #5 clk = ~clk;

  for (genvar m = 0; m < 2; m++) begin : g_dut
    logic        r0, r1, v0, v1;
    logic [31:0] d0, d1;

    alu_share_arbiter #(.PRIORITY_MODE(m)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req_valid[0]),
      .req0_ready  (r0),
      .req0_op0    (op0[0]),
      .req0_op1    (op1[0]),
      .req0_opcode (opc[0]),
      .req1_valid  (req_valid[1]),
      .req1_ready  (r1),
      .req1_op0    (op0[1]),
      .req1_op1    (op1[1]),
      .req1_opcode (opc[1]),
      .rsp0_valid  (v0),
      .rsp0_data   (d0),
      .rsp0_ready  (rsp_ready[0]),
      .rsp1_valid  (v1),
      .rsp1_data   (d1),
      .rsp1_ready  (rsp_ready[1])
    );

    assign rdy_w[m]    = {r1, r0};
    assign vld_w[m]    = {v1, v0};
    assign dat_w[m][0] = d0;
    assign dat_w[m][1] = d1;
  end

  // Reference state: per mode, per port slot contents and last winner.
  bit          full [2][2];
  logic [31:0] sdat [2][2];
  int          last [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      CORE_ALU_ADD:  return a + b;
      CORE_ALU_SUB:  return a - b;
      CORE_ALU_SLL:  return a << b[4:0];
      CORE_ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      CORE_ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      CORE_ALU_XOR:  return a ^ b;
      CORE_ALU_SRL:  return a >> b[4:0];
      CORE_ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
      CORE_ALU_OR:   return a | b;
      CORE_ALU_AND:  return a & b;
      default:       return 32'd0;
    endcase
  endfunction

  // Expected winner for mode m (0 = round-robin, 1 = fixed); -1 means none.
  function automatic int exp_grant(input int m);
    bit e [2];
    for (int i = 0; i < 2; i++)
      e[i] = !rst && req_valid[i] && (!full[m][i] || rsp_ready[i]);
    if (e[0] && e[1]) return (m == 1) ? 0 : ((last[m] == 0) ? 1 : 0);
    if (e[0]) return 0;
    if (e[1]) return 1;
    return -1;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next one.
  task automatic cycle();
    int g [2];
    #1;
    for (int m = 0; m < 2; m++) begin
      g[m] = exp_grant(m);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d_rsp%0d_valid", m, i), 32'(vld_w[m][i]), 32'(full[m][i]));
        check($sformatf("m%0d_rsp%0d_data", m, i), dat_w[m][i], sdat[m][i]);
        check($sformatf("m%0d_req%0d_ready", m, i), 32'(rdy_w[m][i]), 32'(g[m] == i));
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          full[m][i] = 1'b0;
          sdat[m][i] = 32'd0;
        end
        last[m] = 1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (g[m] == i) begin
            full[m][i] = 1'b1;
            sdat[m][i] = ref_alu(opc[i], op0[i], op1[i]);
          end else if (full[m][i] && rsp_ready[i]) begin
            full[m][i] = 1'b0;
          end
        end
        if (g[m] >= 0) last[m] = g[m];
      end
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit v, input logic [3:0] o,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = v;
    opc[i]       = o;
    op0[i]       = a;
    op1[i]       = b;
  endtask

  task automatic repeat_cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  logic [3:0] ops_tbl [10];

  initial begin
    ops_tbl = '{CORE_ALU_ADD, CORE_ALU_SUB, CORE_ALU_SLL, CORE_ALU_SLT, CORE_ALU_SLTU,
                CORE_ALU_XOR, CORE_ALU_SRL, CORE_ALU_SRA, CORE_ALU_OR, CORE_ALU_AND};
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 2; i++) begin
        full[m][i] = 1'b0;
        sdat[m][i] = 32'd0;
      end
      last[m] = 1;
    end
    rst       = 1'b1;
    rsp_ready = 2'b00;
    set_req(0, 1'b1, CORE_ALU_ADD, 32'd1, 32'd2);
    set_req(1, 1'b1, CORE_ALU_ADD, 32'd3, 32'd4);
    @(negedge clk);

    // Reset with requests pending: no grants, empty slots.
    repeat_cycles(3);
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat_cycles(2);
    check("idle_rsp0_valid", 32'(vld_w[0][0]), 32'd0);
    check("idle_rsp1_data", dat_w[0][1], 32'd0);

    // Port 0 alone: ADD 5 + 7.
    set_req(0, 1'b1, CORE_ALU_ADD, 32'd5, 32'd7);
    cycle();
    check("add_valid", 32'(vld_w[0][0]), 32'd1);
    check("add_data_rr", dat_w[0][0], 32'd12);
    check("add_data_fp", dat_w[1][0], 32'd12);
    req_valid = 2'b00;
    cycle();
    check("add_drained", 32'(vld_w[0][0]), 32'd0);

    // Both ports competing for four cycles.
    set_req(0, 1'b1, CORE_ALU_SUB, 32'd10, 32'd3);
    set_req(1, 1'b1, CORE_ALU_SLTU, 32'd1, 32'd2);
    repeat_cycles(4);
    check("tie_sub_rr", dat_w[0][0], 32'd7);
    check("tie_sltu_rr", dat_w[0][1], 32'd1);
    req_valid = 2'b00;
    cycle();

    // Port 1 backpressured: its slot holds while port 0 keeps the ALU.
    set_req(0, 1'b1, CORE_ALU_ADD, 32'd100, 32'd1);
    set_req(1, 1'b1, CORE_ALU_SRA, 32'h8000_0000, 32'd4);
    rsp_ready = 2'b01;
    repeat_cycles(2);
    set_req(1, 1'b1, CORE_ALU_ADD, 32'd9, 32'd9);
    repeat_cycles(4);
    check("sra_held_valid", 32'(vld_w[0][1]), 32'd1);
    check("sra_held_data", dat_w[0][1], 32'hF800_0000);
    rsp_ready = 2'b11;
    repeat_cycles(2);
    req_valid = 2'b00;
    cycle();

    // Fixed priority versus round-robin under a sustained tie.
    set_req(0, 1'b1, CORE_ALU_XOR, 32'hFF00_FF00, 32'h0F0F_0F0F);
    set_req(1, 1'b1, CORE_ALU_OR, 32'h0000_1234, 32'h0000_4321);
    repeat_cycles(3);
    req_valid[0] = 1'b0;
    repeat_cycles(2);
    req_valid = 2'b00;
    cycle();

    // Reset while a result is pending, then a tie right after reset.
    set_req(0, 1'b1, CORE_ALU_SLL, 32'd3, 32'd4);
    cycle();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst = 1'b1;
    cycle();
    check("rst_drop_valid", 32'(vld_w[0][0]), 32'd0);
    check("rst_drop_data", dat_w[0][0], 32'd0);
    rst = 1'b0;
    rsp_ready = 2'b11;
    set_req(0, 1'b1, CORE_ALU_AND, 32'hF0F0, 32'h3C3C);
    set_req(1, 1'b1, CORE_ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    cycle();
    req_valid = 2'b00;
    cycle();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 2; i++) begin
        logic [31:0] a, b;
        a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        set_req(i, ($urandom_range(0, 99) < 65), ops_tbl[$urandom_range(0, 9)], a, b);
        rsp_ready[i] = ($urandom_range(0, 99) < 70);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
